// File: rtl/vec_pkg.sv
// vec_pkg: shared constants and types for the strip-mined vector engine.
// Op codes, FSM state encoding and default sizing live here.
package vec_pkg;

   localparam int DEF_LANES    = 8;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_MAX_VLEN = 64;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_AND   = 3'd2;
   localparam logic [2:0] OP_OR    = 3'd3;
   localparam logic [2:0] OP_XOR   = 3'd4;
   localparam logic [2:0] OP_SLL   = 3'd5;
   localparam logic [2:0] OP_ADDVX = 3'd6;
   localparam logic [2:0] OP_MIN   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/vec_lane_alu.sv
// vec_lane_alu: combinational single-element ALU, one per lane.
// Arithmetic wraps modulo 2^DATA_W; no flags are produced.
module vec_lane_alu
   import vec_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] scalar,
   output logic [DATA_W-1:0] result
);

   localparam int SH_W = $clog2(DATA_W);

   // select the element result for the latched op
   always_comb begin
      result = '0;
      unique case (op)
         OP_ADD:   result = a + b;
         OP_SUB:   result = a - b;
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_XOR:   result = a ^ b;
         OP_SLL:   result = a << b[SH_W-1:0];
         OP_ADDVX: result = a + scalar;
         OP_MIN:   result = ($signed(a) < $signed(b)) ? a : b;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/vec_strip_engine.sv
// vec_strip_engine: strip-mines one vector instruction across LANES lanes,
// sequencing register-file reads and delivering masked writeback beats.
module vec_strip_engine
   import vec_pkg::*;
#(
   parameter int LANES    = DEF_LANES,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_VLEN = DEF_MAX_VLEN,
   parameter int BEAT_W   = $clog2(MAX_VLEN / LANES),
   parameter int VL_W     = $clog2(MAX_VLEN + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [2:0]              req_op,
   input  logic [4:0]              req_vd,
   input  logic [4:0]              req_vs1,
   input  logic [4:0]              req_vs2,
   input  logic [VL_W-1:0]         req_vlen,
   input  logic [DATA_W-1:0]       req_scalar,
   output logic                    rf_rd_en,
   output logic [BEAT_W-1:0]       rf_rd_beat,
   output logic [4:0]              rf_rd_vs1,
   output logic [4:0]              rf_rd_vs2,
   input  logic [LANES*DATA_W-1:0] rf_rd_data1,
   input  logic [LANES*DATA_W-1:0] rf_rd_data2,
   output logic                    wb_valid,
   input  logic                    wb_ready,
   output logic [4:0]              wb_vd,
   output logic [BEAT_W-1:0]       wb_beat,
   output logic [LANES-1:0]        wb_mask,
   output logic [LANES*DATA_W-1:0] wb_data,
   output logic                    busy,
   output logic                    done
);

   localparam int VEC_W = LANES * DATA_W;

   state_t              state;
   logic [2:0]          op_q;
   logic [4:0]          vd_q;
   logic [4:0]          vs1_q;
   logic [4:0]          vs2_q;
   logic [DATA_W-1:0]   scalar_q;
   logic [VL_W-1:0]     vlen_q;
   logic [BEAT_W-1:0]   beat_q;
   logic [BEAT_W-1:0]   last_q;

   logic                pend_v;
   logic [BEAT_W-1:0]   pend_beat;

   logic                skid_v;
   logic [BEAT_W-1:0]   skid_beat;
   logic [LANES-1:0]    skid_mask;
   logic [VEC_W-1:0]    skid_data;

   logic [LANES-1:0]    res_mask;
   logic [VEC_W-1:0]    res_data;

   logic                accept;
   logic                stall;
   logic                hs;
   logic                rd_go;
   logic [VL_W-1:0]     vlen_c;
   logic [VL_W-1:0]     beats_c;

   assign req_ready  = (state == ST_IDLE);
   assign accept     = req_valid && req_ready;
   assign stall      = wb_valid && !wb_ready;
   assign hs         = wb_valid && wb_ready;
   assign rd_go      = (state == ST_RUN) && !skid_v && !stall;
   assign busy       = (state != ST_IDLE);

   assign rf_rd_en   = rd_go;
   assign rf_rd_beat = beat_q;
   assign rf_rd_vs1  = vs1_q;
   assign rf_rd_vs2  = vs2_q;
   assign wb_vd      = vd_q;

   // clamp the requested length and size the strip in beats
   always_comb begin
      vlen_c = req_vlen;
      if (req_vlen > VL_W'(MAX_VLEN)) begin
         vlen_c = VL_W'(MAX_VLEN);
      end
      beats_c = (vlen_c + VL_W'(LANES - 1)) / VL_W'(LANES);
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [DATA_W-1:0] r;
      logic              m;

      vec_lane_alu #(
         .DATA_W (DATA_W)
      ) u_alu (
         .op     (op_q),
         .a      (rf_rd_data1[l*DATA_W +: DATA_W]),
         .b      (rf_rd_data2[l*DATA_W +: DATA_W]),
         .scalar (scalar_q),
         .result (r)
      );

      assign m = (int'(pend_beat) * LANES + l) < int'(vlen_q);
      assign res_mask[l] = m;
      assign res_data[l*DATA_W +: DATA_W] = m ? r : '0;
   end

   // request FSM, beat counter and in-flight read tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_q      <= '0;
         vd_q      <= '0;
         vs1_q     <= '0;
         vs2_q     <= '0;
         scalar_q  <= '0;
         vlen_q    <= '0;
         beat_q    <= '0;
         last_q    <= '0;
         pend_v    <= 1'b0;
         pend_beat <= '0;
         done      <= 1'b0;
      end else begin
         pend_v <= rd_go;
         if (rd_go) begin
            pend_beat <= beat_q;
         end
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q     <= req_op;
                  vd_q     <= req_vd;
                  vs1_q    <= req_vs1;
                  vs2_q    <= req_vs2;
                  scalar_q <= req_scalar;
                  vlen_q   <= vlen_c;
                  beat_q   <= '0;
                  last_q   <= BEAT_W'(beats_c - VL_W'(1));
                  if (vlen_c == '0) begin
                     state <= ST_DRAIN;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (rd_go) begin
                  beat_q <= beat_q + BEAT_W'(1);
                  if (beat_q == last_q) begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (done) begin
                  state <= ST_IDLE;
               end else if (hs && !skid_v && !pend_v) begin
                  done <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // output register plus one-entry skid, strictly in beat order
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid  <= 1'b0;
         wb_beat   <= '0;
         wb_mask   <= '0;
         wb_data   <= '0;
         skid_v    <= 1'b0;
         skid_beat <= '0;
         skid_mask <= '0;
         skid_data <= '0;
      end else begin
         if (hs) begin
            if (skid_v) begin
               wb_beat <= skid_beat;
               wb_mask <= skid_mask;
               wb_data <= skid_data;
               skid_v  <= pend_v;
               if (pend_v) begin
                  skid_beat <= pend_beat;
                  skid_mask <= res_mask;
                  skid_data <= res_data;
               end
            end else if (pend_v) begin
               wb_beat <= pend_beat;
               wb_mask <= res_mask;
               wb_data <= res_data;
            end else begin
               wb_valid <= 1'b0;
            end
         end else if (!wb_valid) begin
            if (pend_v) begin
               wb_valid <= 1'b1;
               wb_beat  <= pend_beat;
               wb_mask  <= res_mask;
               wb_data  <= res_data;
            end
         end else if (pend_v) begin
            skid_v    <= 1'b1;
            skid_beat <= pend_beat;
            skid_mask <= res_mask;
            skid_data <= res_data;
         end
      end
   end

endmodule

// File: tb/tb_vec_strip_engine.sv
// tb_vec_strip_engine: scoreboard bench for vec_strip_engine.
// Register-file model answers reads; expected beats are queued at issue.
module tb_vec_strip_engine;

   localparam int LANES    = 8;
   localparam int DATA_W   = 32;
   localparam int MAX_VLEN = 64;
   localparam int BEAT_W   = 3;
   localparam int VL_W     = 7;
   localparam int VEC_W    = LANES * DATA_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [4:0]        req_vd;
   logic [4:0]        req_vs1;
   logic [4:0]        req_vs2;
   logic [VL_W-1:0]   req_vlen;
   logic [DATA_W-1:0] req_scalar;
   logic              rf_rd_en;
   logic [BEAT_W-1:0] rf_rd_beat;
   logic [4:0]        rf_rd_vs1;
   logic [4:0]        rf_rd_vs2;
   logic [VEC_W-1:0]  rf_rd_data1;
   logic [VEC_W-1:0]  rf_rd_data2;
   logic              wb_valid;
   logic              wb_ready;
   logic [4:0]        wb_vd;
   logic [BEAT_W-1:0] wb_beat;
   logic [LANES-1:0]  wb_mask;
   logic [VEC_W-1:0]  wb_data;
   logic              busy;
   logic              done;

   typedef struct {
      logic [4:0]        vd;
      logic [BEAT_W-1:0] beat;
      logic [LANES-1:0]  mask;
      logic [VEC_W-1:0]  data;
   } exp_t;

   exp_t              sb[$];
   logic [DATA_W-1:0] vrf [32][MAX_VLEN];

   int n_tests = 0;
   int n_fail  = 0;
   int hs_count;
   int rd_count;
   int t_rd, t_wb, t_hs, t_done;
   logic [DATA_W-1:0] lane0;

   vec_strip_engine #(
      .LANES    (LANES),
      .DATA_W   (DATA_W),
      .MAX_VLEN (MAX_VLEN),
      .BEAT_W   (BEAT_W),
      .VL_W     (VL_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_vd      (req_vd),
      .req_vs1     (req_vs1),
      .req_vs2     (req_vs2),
      .req_vlen    (req_vlen),
      .req_scalar  (req_scalar),
      .rf_rd_en    (rf_rd_en),
      .rf_rd_beat  (rf_rd_beat),
      .rf_rd_vs1   (rf_rd_vs1),
      .rf_rd_vs2   (rf_rd_vs2),
      .rf_rd_data1 (rf_rd_data1),
      .rf_rd_data2 (rf_rd_data2),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_vd       (wb_vd),
      .wb_beat     (wb_beat),
      .wb_mask     (wb_mask),
      .wb_data     (wb_data),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // register file: data appears the cycle after the read strobe
   always @(posedge clk) begin
      if (rf_rd_en) begin
         for (int l = 0; l < LANES; l++) begin
            rf_rd_data1[l*DATA_W +: DATA_W] <=
               vrf[rf_rd_vs1][int'(rf_rd_beat) * LANES + l];
            rf_rd_data2[l*DATA_W +: DATA_W] <=
               vrf[rf_rd_vs2][int'(rf_rd_beat) * LANES + l];
         end
      end
   end

   // scoreboard: pop one expected beat per writeback handshake
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (rf_rd_en) rd_count++;
         if (wb_valid && wb_ready) begin
            hs_count++;
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_extra: beat %0d got, none expected", wb_beat);
            end else begin
               e = sb.pop_front();
               if (wb_vd !== e.vd || wb_beat !== e.beat ||
                   wb_mask !== e.mask || wb_data !== e.data) begin
                  n_fail++;
                  $display("FAIL sb_beat: got vd=%0d beat=%0d mask=%h data=%h exp vd=%0d beat=%0d mask=%h data=%h",
                           wb_vd, wb_beat, wb_mask, wb_data,
                           e.vd, e.beat, e.mask, e.data);
               end
            end
         end
      end
   end

   function automatic logic [DATA_W-1:0] ref_alu(
      input logic [2:0]        op,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic [DATA_W-1:0] s
   );
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << b[4:0];
         3'd6:    return a + s;
         default: return ($signed(a) < $signed(b)) ? a : b;
      endcase
   endfunction

   task automatic fill(input int r, input int base, input bit rnd);
      for (int i = 0; i < MAX_VLEN; i++) begin
         vrf[r][i] = rnd ? $urandom() : DATA_W'(base);
      end
   endtask

   task automatic issue(
      input logic [2:0]        op,
      input logic [4:0]        vd,
      input logic [4:0]        vs1,
      input logic [4:0]        vs2,
      input logic [VL_W-1:0]   vl,
      input logic [DATA_W-1:0] sc
   );
      exp_t e;
      int   n;
      int   beats;
      int   k;
      n = (int'(vl) > MAX_VLEN) ? MAX_VLEN : int'(vl);
      beats = (n + LANES - 1) / LANES;
      for (int b = 0; b < beats; b++) begin
         e.vd   = vd;
         e.beat = BEAT_W'(b);
         e.mask = '0;
         e.data = '0;
         for (int l = 0; l < LANES; l++) begin
            if (b * LANES + l < n) begin
               e.mask[l] = 1'b1;
               e.data[l*DATA_W +: DATA_W] =
                  ref_alu(op, vrf[vs1][b*LANES+l], vrf[vs2][b*LANES+l], sc);
            end
         end
         sb.push_back(e);
      end
      k = 0;
      while (!req_ready && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (!req_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL req_ready_timeout: got 0 exp 1");
      end
      req_op = op; req_vd = vd; req_vs1 = vs1; req_vs2 = vs2;
      req_vlen = vl; req_scalar = sc; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic observe(input int max_cyc);
      t_rd = -1; t_wb = -1; t_hs = -1; t_done = -1; lane0 = '0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (rf_rd_en && t_rd < 0) t_rd = i;
         if (wb_valid && t_wb < 0) begin
            t_wb = i;
            lane0 = wb_data[DATA_W-1:0];
         end
         if (wb_valid && wb_ready) t_hs = i;
         if (done) begin
            t_done = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({wb_valid, rf_rd_en, busy, done} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b exp 0000",
                  {wb_valid, rf_rd_en, busy, done});
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b exp 1", req_ready);
      end
      n_tests++;
      if (wb_data !== '0 || wb_mask !== '0 || wb_beat !== '0 || wb_vd !== '0) begin
         n_fail++;
         $display("FAIL reset_wb: got mask=%h beat=%0d vd=%0d data=%h exp 0",
                  wb_mask, wb_beat, wb_vd, wb_data);
      end
      n_tests++;
      if (rf_rd_beat !== '0 || rf_rd_vs1 !== '0 || rf_rd_vs2 !== '0) begin
         n_fail++;
         $display("FAIL reset_rf: got beat=%0d vs1=%0d vs2=%0d exp 0",
                  rf_rd_beat, rf_rd_vs1, rf_rd_vs2);
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < MAX_VLEN; i++) vrf[1][i] = DATA_W'(i);
      fill(2, 100, 1'b0);
      hs_count = 0; rd_count = 0;
      issue(3'd0, 5'd3, 5'd1, 5'd2, 7'd8, 32'd0);
      observe(30);
      n_tests++;
      if (t_rd !== 0) begin
         n_fail++;
         $display("FAIL basic_first_rd: got cycle %0d exp 0", t_rd);
      end
      n_tests++;
      if (t_wb - t_rd !== 2) begin
         n_fail++;
         $display("FAIL basic_rd_to_wb: got %0d exp 2", t_wb - t_rd);
      end
      n_tests++;
      if (t_done < 0 || t_done - t_hs !== 1) begin
         n_fail++;
         $display("FAIL basic_done: got hs=%0d done=%0d exp done=hs+1", t_hs, t_done);
      end
      n_tests++;
      if (lane0 !== 32'd100 || hs_count !== 1 || sb.size() !== 0) begin
         n_fail++;
         $display("FAIL basic_beats: got lane0=%0d hs=%0d left=%0d exp 100 1 0",
                  lane0, hs_count, sb.size());
      end
   endtask

   task automatic test_tail();
      fill(6, 0, 1'b1);
      fill(7, 0, 1'b1);
      hs_count = 0; rd_count = 0;
      issue(3'd3, 5'd8, 5'd6, 5'd7, 7'd19, 32'd0);
      observe(40);
      n_tests++;
      if (t_done < 0 || hs_count !== 3 || sb.size() !== 0) begin
         n_fail++;
         $display("FAIL tail19: got done=%0d hs=%0d left=%0d exp 3 beats",
                  t_done, hs_count, sb.size());
      end
      hs_count = 0; rd_count = 0;
      issue(3'd4, 5'd9, 5'd6, 5'd7, 7'd100, 32'd0);
      observe(40);
      n_tests++;
      if (hs_count !== 8 || rd_count !== 8 || sb.size() !== 0) begin
         n_fail++;
         $display("FAIL clamp: got hs=%0d rd=%0d left=%0d exp 8 8 0",
                  hs_count, rd_count, sb.size());
      end
      n_tests++;
      if (t_rd !== 0 || t_done !== 10) begin
         n_fail++;
         $display("FAIL throughput: got rd=%0d done=%0d exp 0 10", t_rd, t_done);
      end
   endtask

   task automatic test_backpressure();
      logic [VEC_W-1:0] snap;
      int k;
      fill(12, 0, 1'b1);
      fill(13, 0, 1'b1);
      hs_count = 0; rd_count = 0;
      issue(3'd0, 5'd14, 5'd12, 5'd13, 7'd64, 32'd0);
      k = 0;
      while (!(wb_valid && wb_beat == 3'd3) && k < 30) begin
         @(posedge clk); #1;
         k++;
      end
      n_tests++;
      if (!(wb_valid && wb_beat == 3'd3)) begin
         n_fail++;
         $display("FAIL bp_reach_beat3: got valid=%b beat=%0d exp 1 3",
                  wb_valid, wb_beat);
      end
      wb_ready = 1'b0;
      snap = wb_data;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_tests++;
         if (wb_valid !== 1'b1 || wb_beat !== 3'd3 ||
             wb_data !== snap || rf_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: got valid=%b beat=%0d rd=%b data=%h exp 1 3 0 %h",
                     wb_valid, wb_beat, rf_rd_en, wb_data, snap);
         end
      end
      @(posedge clk); #1;
      wb_ready = 1'b1;
      observe(60);
      n_tests++;
      if (t_done < 0 || hs_count !== 8 || rd_count !== 8 || sb.size() !== 0) begin
         n_fail++;
         $display("FAIL bp_delivery: got done=%0d hs=%0d rd=%0d left=%0d exp 8 8 0",
                  t_done, hs_count, rd_count, sb.size());
      end
   endtask

   task automatic test_zero();
      hs_count = 0; rd_count = 0;
      issue(3'd0, 5'd1, 5'd2, 5'd3, 7'd0, 32'd0);
      @(negedge clk);
      n_tests++;
      if (done !== 1'b1 || rf_rd_en !== 1'b0 || wb_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_done: got done=%b rd=%b wbv=%b exp 1 0 0",
                  done, rf_rd_en, wb_valid);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_idle: got done=%b ready=%b exp 0 1", done, req_ready);
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if (hs_count !== 0 || rd_count !== 0) begin
         n_fail++;
         $display("FAIL zero_activity: got hs=%0d rd=%0d exp 0 0", hs_count, rd_count);
      end
   endtask

   task automatic test_ops();
      logic [DATA_W-1:0] sc;
      logic [DATA_W-1:0] want;
      for (int o = 0; o < 8; o++) begin
         fill(10, 0, 1'b1);
         fill(11, 0, 1'b1);
         sc = $urandom();
         want = '0;
         case (o)
            1: begin vrf[10][0] = 32'd0; vrf[11][0] = 32'd1; want = 32'hFFFF_FFFF; end
            5: begin vrf[10][0] = 32'd1; vrf[11][0] = 32'd33; want = 32'd2; end
            6: begin vrf[10][0] = 32'd1; sc = 32'hFFFF_FFFF; want = 32'd0; end
            7: begin vrf[10][0] = 32'h8000_0000; vrf[11][0] = 32'd1; want = 32'h8000_0000; end
            default: ;
         endcase
         issue(3'(o), 5'd20, 5'd10, 5'd11, 7'd8, sc);
         observe(30);
         n_tests++;
         if (t_done < 0 || sb.size() !== 0) begin
            n_fail++;
            $display("FAIL op%0d_complete: got done=%0d left=%0d exp done", o, t_done, sb.size());
         end
         if (o == 1 || o == 5 || o == 6 || o == 7) begin
            n_tests++;
            if (lane0 !== want) begin
               n_fail++;
               $display("FAIL op%0d_corner: got %h exp %h", o, lane0, want);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int k;
      int dn;
      fill(15, 0, 1'b1);
      fill(16, 0, 1'b1);
      issue(3'd2, 5'd17, 5'd15, 5'd16, 7'd64, 32'd0);
      k = 0;
      while (!(rf_rd_en && rf_rd_beat == 3'd2) && k < 30) begin
         @(posedge clk); #1;
         k++;
      end
      rst = 1'b1;
      #1;
      sb.delete();
      n_tests++;
      if ({wb_valid, rf_rd_en, busy, done} !== 4'b0 ||
          wb_data !== '0 || wb_mask !== '0 || wb_beat !== '0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got v=%b rd=%b busy=%b done=%b mask=%h exp all 0",
                  wb_valid, rf_rd_en, busy, done, wb_mask);
      end
      dn = 0;
      repeat (2) begin
         @(negedge clk);
         if (done) dn++;
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) dn++;
      end
      n_tests++;
      if (dn !== 0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_nodone: got done_cycles=%0d ready=%b exp 0 1", dn, req_ready);
      end
      @(posedge clk); #1;
      hs_count = 0; rd_count = 0;
      issue(3'd1, 5'd18, 5'd15, 5'd16, 7'd24, 32'd0);
      observe(40);
      n_tests++;
      if (t_done < 0 || hs_count !== 3 || sb.size() !== 0) begin
         n_fail++;
         $display("FAIL midrst_after: got done=%0d hs=%0d left=%0d exp 3 0",
                  t_done, hs_count, sb.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      req_op = '0; req_vd = '0; req_vs1 = '0; req_vs2 = '0;
      req_vlen = '0; req_scalar = '0;
      wb_ready = 1'b1;
      hs_count = 0; rd_count = 0;
      test_reset();
      test_basic();
      test_tail();
      test_backpressure();
      test_zero();
      test_ops();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
